// File: rtl/perf_sample_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : perf_sample_pkg                                                  |
// | Purpose : Shared types for the performance sampling unit: the per-window   |
// |           sample record, the sampler FSM states and a wrap-safe delta      |
// |           helper.                                                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package perf_sample_pkg;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] mispredict;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } perf_state_e;

  // Field-wise modulo-2^32 difference; stays correct when a monitor
  // counter wraps inside the window.
  function automatic sample_t sample_delta(input sample_t cur, input sample_t base);
    sample_t d;
    d.total      = cur.total      - base.total;
    d.stall      = cur.stall      - base.stall;
    d.mispredict = cur.mispredict - base.mispredict;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perf_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : perf_sample_fifo                                                 |
// | Purpose : Small synchronous FIFO whose head entry is a register, so the    |
// |           output data comes straight from flops.                           |
// | Ports   : clk, rst      - clock, synchronous active-high reset            |
// |           i_push/i_data - write request and data                           |
// |           i_pop         - reader ready; pops only when non-empty           |
// |           o_head        - oldest entry (valid when !o_empty)               |
// |           o_empty/o_full- occupancy flags                                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module perf_sample_fifo
  import perf_sample_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;

  logic             w_pop;
  logic             w_push_ok;
  logic [AW-1:0]    w_wr_idx;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  // A pop needs something to pop: push+pop on an empty FIFO is a pure push.
  assign w_pop     = !o_empty && i_pop;
  // A pop on the same edge frees the slot a full FIFO needs.
  assign w_push_ok = i_push && (!o_full || w_pop);
  // Entry 0 is the head; the new entry lands just past the last survivor.
  // With a power-of-two depth, count==DEPTH wraps to 0 here and the
  // subtraction of the pop brings it back to DEPTH-1.
  assign w_wr_idx  = r_count[AW-1:0] - AW'(w_pop);
  assign o_head    = r_mem[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
      end
      if (w_push_ok) r_mem[w_wr_idx] <= i_data;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/perf_sample_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : perf_sample_unit                                                 |
// | Purpose : Slices the free-running pipeline monitor counters into abutting  |
// |           WINDOW_CYCLES-long windows, queues each window's deltas and      |
// |           streams them out on a valid/ready interface.                     |
// | Ports   : clk, rst            - clock, synchronous active-high reset      |
// |           enable              - sampling enable                            |
// |           total_cycles, stall_cycles, branch_mispredicts - monitor inputs  |
// |           sample_valid/ready  - output stream handshake                    |
// |           sample_total/stall/mispredict - head sample                      |
// |           drop_count          - saturating count of dropped samples        |
// |           overflow            - sticky, set on first drop                  |
// | Option  : PERF_SAMPLE_ALARM_EN adds stall_thresh (in) and stall_alarm      |
// |           (out), a one-cycle pulse after a window whose stall delta        |
// |           exceeds stall_thresh.                                            |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module perf_sample_unit
  import perf_sample_pkg::*;
#(
  parameter int WINDOW_CYCLES = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int DROP_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PERF_SAMPLE_ALARM_EN
  input  logic [CNT_W-1:0]  stall_thresh,
  output logic              stall_alarm,
`endif
  input  logic              enable,
  input  logic [CNT_W-1:0]  total_cycles,
  input  logic [CNT_W-1:0]  stall_cycles,
  input  logic [CNT_W-1:0]  branch_mispredicts,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [CNT_W-1:0]  sample_total,
  output logic [CNT_W-1:0]  sample_stall,
  output logic [CNT_W-1:0]  sample_mispredict,
  output logic [DROP_W-1:0] drop_count,
  output logic              overflow
);

  localparam int               c_win_w    = 16;
  localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_CYCLES - 1);

  perf_state_e        r_state;
  perf_state_e        w_state_next;
  logic               w_load_base;
  logic               w_cnt_clr;
  logic               w_cnt_inc;
  logic               w_close;

  logic [c_win_w-1:0] r_win_cnt;
  sample_t            r_base;
  sample_t            w_cur;
  sample_t            w_delta;
  sample_t            w_head;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_drop;
  logic [DROP_W-1:0]  r_drop_count;
  logic               r_overflow;

  assign w_cur.total      = total_cycles;
  assign w_cur.stall      = stall_cycles;
  assign w_cur.mispredict = branch_mispredicts;
  assign w_delta          = sample_delta(w_cur, r_base);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load_base  = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_close      = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = RUN;
          w_load_base  = 1'b1;
          w_cnt_clr    = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else if (r_win_cnt == c_win_last) begin
          // Close and immediately reopen: the same-cycle inputs are both
          // this window's end point and the next window's base.
          w_close     = 1'b1;
          w_load_base = 1'b1;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_cnt <= '0;
      r_base    <= '0;
    end else begin
      if (w_cnt_clr)      r_win_cnt <= '0;
      else if (w_cnt_inc) r_win_cnt <= r_win_cnt + c_win_w'(1);
      if (w_load_base)    r_base    <= w_cur;
    end
  end

  perf_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_close),
    .i_data  (w_delta),
    .i_pop   (sample_ready),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign sample_valid      = !w_fifo_empty;
  assign sample_total      = w_head.total;
  assign sample_stall      = w_head.stall;
  assign sample_mispredict = w_head.mispredict;

  // A same-edge pop makes room, so only a push into a full, non-draining
  // FIFO is lost.
  assign w_drop = w_close && w_fifo_full && !(sample_valid && sample_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else if (w_drop) begin
      if (r_drop_count != {DROP_W{1'b1}}) r_drop_count <= r_drop_count + DROP_W'(1);
      r_overflow <= 1'b1;
    end
  end

  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;

`ifdef PERF_SAMPLE_ALARM_EN
  // Evaluated on the delta itself, so it fires even when the sample is dropped.
  logic r_stall_alarm;

  always_ff @(posedge clk) begin
    if (rst) r_stall_alarm <= 1'b0;
    else     r_stall_alarm <= w_close && (w_delta.stall > stall_thresh);
  end

  assign stall_alarm = r_stall_alarm;
`endif

endmodule
`default_nettype wire
